dmem_arbiter: RTL and testbench

- Shares the single data-memory port between the core memory stage (requester C) and an external master (requester X), e.g. UART programmer or debug DMA.
- Drives the memory-side enable/address/data signals and generates `mem_hold` to stall the core pipeline.
- Routes read data back to whichever requester issued the read.
- Core has fixed priority, bounded by an anti-starvation counter for X.

---
 rtl/dmem_arbiter.sv | 155 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares one data-memory port between the core memory stage (C) and an
// external master (X). The core has fixed priority, except that X takes the
// port once it has been denied MAX_WAIT consecutive idle cycles. Reads hold
// the port for RD_LAT cycles after issue; read data is steered back to the
// requester that issued it.
//
// Ports:
//   clk, Rst_n        clock, synchronous active-low reset
//   c_*               core request (byte enables, write, read, addr, data)
//   c_dout            core read data (live in the done cycle, held after)
//   mem_hold          stalls the core while its request is not yet complete
//   x_*               external master request / handshake / read return
//   m_*               memory-side port (m_dout is the memory read data)
module dmem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              Rst_n,
  input  logic [3:0]        c_en,
  input  logic              c_wea,
  input  logic              c_rea,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_din,
  output logic [DATA_W-1:0] c_dout,
  output logic              mem_hold,
  input  logic              x_req,
  input  logic              x_we,
  input  logic [3:0]        x_be,
  input  logic [ADDR_W-1:0] x_addr,
  input  logic [DATA_W-1:0] x_din,
  output logic              x_gnt,
  output logic              x_rvalid,
  output logic [DATA_W-1:0] x_rdata,
  output logic [3:0]        m_en,
  output logic              m_wea,
  output logic              m_rea,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_din,
  input  logic [DATA_W-1:0] m_dout
);

  typedef enum logic [0:0] {IDLE, RD_WAIT} state_t;

  state_t            state;
  logic              owner_x;     // 1: the outstanding read belongs to X
  logic [2:0]        lat_cnt;
  logic [3:0]        starve_cnt;
  logic [DATA_W-1:0] c_dout_q;
  logic [DATA_W-1:0] x_rdata_q;

  logic core_req;
  logic x_prio;
  logic c_issue;
  logic x_issue;
  logic rd_done;
  logic c_rd_done;
  logic x_rd_done;
  logic core_done;

  // Everything visible to the outside is gated with Rst_n so that all
  // strobes are quiet in the very first reset cycle, before the state
  // registers have been cleared.
  assign core_req  = (|c_en) & (c_wea | c_rea);
  assign x_prio    = x_req & (starve_cnt == 4'(MAX_WAIT));
  assign c_issue   = Rst_n & (state == IDLE) & core_req & ~x_prio;
  assign x_issue   = Rst_n & (state == IDLE) & x_req & ~(core_req & ~x_prio);
  assign rd_done   = Rst_n & (state == RD_WAIT) & (lat_cnt == 3'(RD_LAT));
  assign c_rd_done = rd_done & ~owner_x;
  assign x_rd_done = rd_done & owner_x;

  // A core write completes in its issue cycle; c_wea wins over c_rea.
  assign core_done = (c_issue & c_wea) | c_rd_done;
  assign mem_hold  = Rst_n & core_req & ~core_done;

  assign x_gnt    = x_issue;
  assign x_rvalid = x_rd_done;
  assign x_rdata  = x_rd_done ? m_dout : (Rst_n ? x_rdata_q : '0);
  assign c_dout   = c_rd_done ? m_dout : c_dout_q;

  // The memory port is driven straight from the winner in the issue cycle.
  always_comb begin
    m_en   = '0;
    m_wea  = 1'b0;
    m_rea  = 1'b0;
    m_addr = '0;
    m_din  = '0;
    if (c_issue) begin
      m_en   = c_en;
      m_wea  = c_wea;
      m_rea  = ~c_wea;
      m_addr = c_addr;
      m_din  = c_din;
    end else if (x_issue) begin
      m_en   = x_be;
      m_wea  = x_we;
      m_rea  = ~x_we;
      m_addr = x_addr;
      m_din  = x_din;
    end
  end

  always_ff @(posedge clk) begin
    if (!Rst_n) begin
      state      <= IDLE;
      owner_x    <= 1'b0;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      c_dout_q   <= '0;
      x_rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (c_issue) begin
            owner_x <= 1'b0;
            if (!c_wea) begin
              state   <= RD_WAIT;
              lat_cnt <= 3'd1;
            end
          end else if (x_issue) begin
            owner_x <= 1'b1;
            if (!x_we) begin
              state   <= RD_WAIT;
              lat_cnt <= 3'd1;
            end
          end
          // Counts denied idle cycles only; frozen while a read is pending.
          if (x_issue) begin
            starve_cnt <= '0;
          end else if (x_req && (starve_cnt != 4'(MAX_WAIT))) begin
            starve_cnt <= starve_cnt + 4'd1;
          end
        end
        RD_WAIT: begin
          if (lat_cnt == 3'(RD_LAT)) begin
            state   <= IDLE;
            lat_cnt <= '0;
            if (owner_x) begin
              x_rdata_q <= m_dout;
            end else begin
              c_dout_q <= m_dout;
            end
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Three arbiter instances (RD_LAT = 1, 2, 3), each attached to its own small
// byte-writable memory model whose read data follows the last read address.
// Stimulus tasks push expected x_gnt / x_rvalid / core-read-done events into
// queues; a monitor process pops and compares whenever the DUT shows them.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_n    [3];
  logic [3:0]  c_en     [3];
  logic        c_wea    [3];
  logic        c_rea    [3];
  logic [31:0] c_addr   [3];
  logic [31:0] c_din    [3];
  logic [31:0] c_dout   [3];
  logic        mem_hold [3];
  logic        x_req    [3];
  logic        x_we     [3];
  logic [3:0]  x_be     [3];
  logic [31:0] x_addr   [3];
  logic [31:0] x_din    [3];
  logic        x_gnt    [3];
  logic        x_rvalid [3];
  logic [31:0] x_rdata  [3];
  logic [3:0]  m_en     [3];
  logic        m_wea    [3];
  logic        m_rea    [3];
  logic [31:0] m_addr   [3];
  logic [31:0] m_din    [3];
  logic [31:0] m_dout   [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(g + 1), .MAX_WAIT(4)) u (
      .clk(clk), .Rst_n(rst_n[g]),
      .c_en(c_en[g]), .c_wea(c_wea[g]), .c_rea(c_rea[g]), .c_addr(c_addr[g]),
      .c_din(c_din[g]), .c_dout(c_dout[g]), .mem_hold(mem_hold[g]),
      .x_req(x_req[g]), .x_we(x_we[g]), .x_be(x_be[g]), .x_addr(x_addr[g]),
      .x_din(x_din[g]), .x_gnt(x_gnt[g]), .x_rvalid(x_rvalid[g]), .x_rdata(x_rdata[g]),
      .m_en(m_en[g]), .m_wea(m_wea[g]), .m_rea(m_rea[g]), .m_addr(m_addr[g]),
      .m_din(m_din[g]), .m_dout(m_dout[g])
    );

    logic [31:0] mem [256];
    logic [7:0]  raddr = 8'd0;
    always @(posedge clk) begin
      if (m_wea[g]) begin
        for (int b = 0; b < 4; b++)
          if (m_en[g][b]) mem[m_addr[g][9:2]][8*b +: 8] <= m_din[g][8*b +: 8];
      end
      if (m_rea[g]) raddr <= m_addr[g][9:2];
    end
    assign m_dout[g] = mem[raddr];
  end

  typedef struct {
    int          inst;
    int          cyc;
    logic [31:0] data;
  } exp_t;

  exp_t q_gnt[$];
  exp_t q_xrv[$];
  exp_t q_crd[$];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (x_gnt[i]) begin
          if (q_gnt.size() == 0) fail_now($sformatf("x_gnt_unexpected inst=%0d", i));
          else begin
            e = q_gnt.pop_front();
            chk("x_gnt_inst", i, e.inst);
            chk("x_gnt_cycle", cyc, e.cyc);
          end
        end
        if (x_rvalid[i]) begin
          if (q_xrv.size() == 0) fail_now($sformatf("x_rvalid_unexpected inst=%0d", i));
          else begin
            e = q_xrv.pop_front();
            chk("x_rvalid_inst", i, e.inst);
            chk("x_rvalid_cycle", cyc, e.cyc);
            chk("x_rdata", x_rdata[i], e.data);
          end
        end
        if (rst_n[i] && (|c_en[i]) && c_rea[i] && !c_wea[i] && !mem_hold[i]) begin
          if (q_crd.size() == 0) fail_now($sformatf("core_done_unexpected inst=%0d", i));
          else begin
            e = q_crd.pop_front();
            chk("c_done_inst", i, e.inst);
            chk("c_done_cycle", cyc, e.cyc);
            chk("c_dout", c_dout[i], e.data);
          end
        end
      end
    end
  endtask

  // Core request held until mem_hold drops; returns the cycle the memory
  // port carried this request.
  task automatic core_op(input int i, input logic we, input logic re,
                         input logic [31:0] addr, input logic [31:0] din,
                         input int exp_stall, input logic [31:0] exp_data,
                         output int iss);
    int n = 0;
    bit done = 0;
    int t0;
    iss = -1;
    t0 = cyc;
    c_en[i] = 4'hF; c_wea[i] = we; c_rea[i] = re; c_addr[i] = addr; c_din[i] = din;
    if (re && !we) q_crd.push_back(exp_t'{i, t0 + exp_stall, exp_data});
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (iss < 0 && (m_wea[i] || m_rea[i]) && m_addr[i] == addr) iss = cyc;
      if (!mem_hold[i]) done = 1;
      else n++;
    end
    if (!done) fail_now("core_op_timeout");
    chk("core_stall", n, exp_stall);
    @(posedge clk); #1;
    c_en[i] = 4'h0; c_wea[i] = 1'b0; c_rea[i] = 1'b0;
  endtask

  // X request held until x_gnt; expected grant at drive cycle + gnt_off,
  // read data expected RD_LAT (= i+1) cycles after the grant.
  task automatic x_op(input int i, input logic we, input logic [31:0] addr,
                      input logic [31:0] din, input int gnt_off, input bit exp_rv,
                      input logic [31:0] exp_data);
    int t0;
    bit got = 0;
    t0 = cyc;
    x_req[i] = 1'b1; x_we[i] = we; x_be[i] = 4'hF; x_addr[i] = addr; x_din[i] = din;
    q_gnt.push_back(exp_t'{i, t0 + gnt_off, 32'h0});
    if (exp_rv) q_xrv.push_back(exp_t'{i, t0 + gnt_off + i + 1, exp_data});
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (x_gnt[i]) got = 1;
    end
    if (!got) fail_now("x_op_timeout");
    @(posedge clk); #1;
    x_req[i] = 1'b0;
  endtask

  task automatic chk_quiet(input int i, input string tag);
    chk({tag, "_mem_hold"}, 32'(mem_hold[i]), 0);
    chk({tag, "_x_gnt"},    32'(x_gnt[i]), 0);
    chk({tag, "_x_rvalid"}, 32'(x_rvalid[i]), 0);
    chk({tag, "_m_en"},     32'(m_en[i]), 0);
    chk({tag, "_m_wea"},    32'(m_wea[i]), 0);
    chk({tag, "_m_rea"},    32'(m_rea[i]), 0);
    chk({tag, "_x_rdata"},  x_rdata[i], 0);
  endtask

  initial begin
    int iss;
    int prev;
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0;
      c_en[i] = 0; c_wea[i] = 0; c_rea[i] = 0; c_addr[i] = 0; c_din[i] = 0;
      x_req[i] = 0; x_we[i] = 0; x_be[i] = 0; x_addr[i] = 0; x_din[i] = 0;
    end
    fork
      monitor();
      begin
        #200000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
      end
    join_none

    // Reset with live requests on every instance: nothing may leak out.
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      c_en[i] = 4'hF; c_wea[i] = 1'b1; c_addr[i] = 32'h10; c_din[i] = 32'h1;
      x_req[i] = 1'b1; x_we[i] = 1'b1; x_be[i] = 4'hF;
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk_quiet(i, "reset");
      chk("reset_c_dout", c_dout[i], 0);
    end
    for (int i = 0; i < 3; i++) begin
      c_en[i] = 0; c_wea[i] = 0; x_req[i] = 0; x_we[i] = 0;
    end
    tick(1);
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
    tick(1);

    // RD_LAT=1: core write then read back.
    core_op(0, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 0, 32'h0, iss);
    core_op(0, 1'b0, 1'b1, 32'h100, 32'h0, 1, 32'hDEADBEEF, iss);

    // X write to preload, then X read; x_rdata must hold afterwards.
    x_op(0, 1'b1, 32'h40, 32'h12345678, 0, 1'b0, 32'h0);
    x_op(0, 1'b0, 32'h40, 32'h0, 0, 1'b1, 32'h12345678);
    tick(3);
    @(negedge clk);
    chk("x_rdata_hold", x_rdata[0], 32'h12345678);
    tick(1);

    // Continuous core reads against a waiting X read: X wins after 4 denials.
    fork
      begin
        for (int k = 0; k < 4; k++) core_op(0, 1'b0, 1'b1, 32'h100, 32'h0, 1, 32'hDEADBEEF, iss);
        core_op(0, 1'b0, 1'b1, 32'h100, 32'h0, 3, 32'hDEADBEEF, iss);
      end
      x_op(0, 1'b0, 32'h40, 32'h0, 8, 1'b1, 32'h12345678);
    join
    chk("starve_cleared", 32'(g_dut[0].u.starve_cnt), 0);

    // Same-cycle core write and X write: core first, X one cycle later.
    fork
      core_op(0, 1'b1, 1'b0, 32'h200, 32'hA5A5A5A5, 0, 32'h0, iss);
      x_op(0, 1'b1, 32'h204, 32'h5A5A5A5A, 1, 1'b0, 32'h0);
    join
    core_op(0, 1'b0, 1'b1, 32'h200, 32'h0, 1, 32'hA5A5A5A5, iss);
    core_op(0, 1'b0, 1'b1, 32'h204, 32'h0, 1, 32'h5A5A5A5A, iss);

    // RD_LAT=3: reset lands in the second wait cycle of an X read.
    x_op(2, 1'b1, 32'h80, 32'hCAFEF00D, 0, 1'b0, 32'h0);
    x_op(2, 1'b0, 32'h80, 32'h0, 0, 1'b0, 32'h0);
    tick(1);
    rst_n[2] = 1'b0;
    c_en[2] = 4'hF; c_rea[2] = 1'b1; c_addr[2] = 32'h80;
    @(negedge clk);
    chk_quiet(2, "midrd_rst0");
    tick(1);
    @(negedge clk);
    chk_quiet(2, "midrd_rst1");
    c_en[2] = 0; c_rea[2] = 0;
    tick(1);
    rst_n[2] = 1'b1;
    chk("fsm_idle_after_rst", 32'(g_dut[2].u.state), 0);
    tick(4);
    x_op(2, 1'b0, 32'h80, 32'h0, 0, 1'b1, 32'hCAFEF00D);
    tick(4);

    // RD_LAT=2: preload, write with both c_wea and c_rea, back-to-back reads.
    core_op(1, 1'b1, 1'b0, 32'h300, 32'h11111111, 0, 32'h0, iss);
    core_op(1, 1'b1, 1'b0, 32'h304, 32'h22222222, 0, 32'h0, iss);
    core_op(1, 1'b1, 1'b0, 32'h308, 32'h33333333, 0, 32'h0, iss);
    core_op(1, 1'b1, 1'b1, 32'h30C, 32'h44444444, 0, 32'h0, iss);
    core_op(1, 1'b0, 1'b1, 32'h300, 32'h0, 2, 32'h11111111, iss);
    prev = iss;
    core_op(1, 1'b0, 1'b1, 32'h304, 32'h0, 2, 32'h22222222, iss);
    chk("rd_spacing_1", iss - prev, 3);
    prev = iss;
    core_op(1, 1'b0, 1'b1, 32'h308, 32'h0, 2, 32'h33333333, iss);
    chk("rd_spacing_2", iss - prev, 3);
    core_op(1, 1'b0, 1'b1, 32'h30C, 32'h0, 2, 32'h44444444, iss);

    tick(3);
    chk("q_gnt_drained", q_gnt.size(), 0);
    chk("q_xrv_drained", q_xrv.size(), 0);
    chk("q_crd_drained", q_crd.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
